// File: rtl/zero_detect_pkg.sv
// Shared constants and helpers for the pipelined all-zero / all-ones detector.
package zero_detect_pkg;

    localparam logic MODE_ZERO = 1'b0;
    localparam logic MODE_ONES = 1'b1;

    function automatic int ngroup(input int width, input int group);
        return width / group;
    endfunction

endpackage

// File: rtl/group_detect.sv
// Combinational leaf: 1 when the slice is all-zeros (mode 0) or all-ones (mode 1).
module group_detect
    import zero_detect_pkg::*;
#(
    parameter int GROUP = 16
) (
    input  logic [GROUP-1:0] slice_i,
    input  logic             mode_i,
    output logic             hit_o
);

    assign hit_o = (mode_i == MODE_ONES) ? (&slice_i) : ~(|slice_i);

endmodule

// File: rtl/zero_detect_pipe.sv
// Two-stage pipelined zero/ones detector with valid/ready handshakes and a Z/N flag register.
module zero_detect_pipe
    import zero_detect_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int GROUP = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    input  logic             in_setflags,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_hit,
    output logic             out_neg,
    output logic             flag_z,
    output logic             flag_n,
    input  logic             flag_clr
);

    localparam int NGROUP = ngroup(WIDTH, GROUP);

    if (WIDTH % GROUP != 0) begin : g_bad_width
        $error("zero_detect_pipe: WIDTH (%0d) must be a multiple of GROUP (%0d)", WIDTH, GROUP);
    end

    logic [NGROUP-1:0] leaf_hit;

    for (genvar k = 0; k < NGROUP; k++) begin : g_leaf
        group_detect #(.GROUP(GROUP)) u_leaf (
            .slice_i (in_data[k*GROUP +: GROUP]),
            .mode_i  (in_mode),
            .hit_o   (leaf_hit[k])
        );
    end

    logic              s1_valid_q, s1_valid_d;
    logic [NGROUP-1:0] s1_g_q,     s1_g_d;
    logic              s1_neg_q,   s1_neg_d;
    logic              s1_sf_q,    s1_sf_d;
    logic              s2_valid_q, s2_valid_d;
    logic              s2_hit_q,   s2_hit_d;
    logic              s2_neg_q,   s2_neg_d;
    logic              s2_sf_q,    s2_sf_d;
    logic              flag_z_q,   flag_z_d;
    logic              flag_n_q,   flag_n_d;

    logic accept;
    logic s2_load;
    logic handshake;

    // S1 can take a new operand whenever it is empty or its contents move on this cycle.
    assign in_ready  = ~s1_valid_q | ~s2_valid_q | out_ready;
    assign accept    = in_valid & in_ready;
    assign s2_load   = s1_valid_q & (~s2_valid_q | out_ready);
    assign handshake = s2_valid_q & out_ready;

    always_comb begin
        // NOTE: every _d gets its hold value first, so no path can infer a latch.
        s1_valid_d = s1_valid_q;
        s1_g_d     = s1_g_q;
        s1_neg_d   = s1_neg_q;
        s1_sf_d    = s1_sf_q;
        s2_valid_d = s2_valid_q;
        s2_hit_d   = s2_hit_q;
        s2_neg_d   = s2_neg_q;
        s2_sf_d    = s2_sf_q;
        flag_z_d   = flag_z_q;
        flag_n_d   = flag_n_q;

        if (accept) begin
            s1_valid_d = 1'b1;
            s1_g_d     = leaf_hit;
            s1_neg_d   = in_data[WIDTH-1];
            s1_sf_d    = in_setflags;
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end

        if (s2_load) begin
            s2_valid_d = 1'b1;
            s2_hit_d   = &s1_g_q;
            s2_neg_d   = s1_neg_q;
            s2_sf_d    = s1_sf_q;
        end else if (out_ready) begin
            s2_valid_d = 1'b0;
        end

        if (flag_clr) begin
            flag_z_d = 1'b0;
            flag_n_d = 1'b0;
        end else if (handshake && s2_sf_q) begin
            flag_z_d = s2_hit_q;
            flag_n_d = s2_neg_q;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: all state uses non-blocking assignment so every register samples pre-edge values.
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s1_g_q     <= '0;
            s1_neg_q   <= 1'b0;
            s1_sf_q    <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_hit_q   <= 1'b0;
            s2_neg_q   <= 1'b0;
            s2_sf_q    <= 1'b0;
            flag_z_q   <= 1'b0;
            flag_n_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_g_q     <= s1_g_d;
            s1_neg_q   <= s1_neg_d;
            s1_sf_q    <= s1_sf_d;
            s2_valid_q <= s2_valid_d;
            s2_hit_q   <= s2_hit_d;
            s2_neg_q   <= s2_neg_d;
            s2_sf_q    <= s2_sf_d;
            flag_z_q   <= flag_z_d;
            flag_n_q   <= flag_n_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_hit   = s2_hit_q;
    assign out_neg   = s2_neg_q;
    assign flag_z    = flag_z_q;
    assign flag_n    = flag_n_q;

endmodule

// File: tb/tb_zero_detect_pipe.sv
// Bench for zero_detect_pipe: queue-level reference model plus directed literal checks.
module tb_zero_detect_pipe;

    localparam int W = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset_n, in_valid, in_mode, in_setflags, out_ready, flag_clr;
    logic [W-1:0] in_data;
    logic         in_ready, out_valid, out_hit, out_neg, flag_z, flag_n;

    zero_detect_pipe #(.WIDTH(64), .GROUP(16)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_mode(in_mode), .in_setflags(in_setflags),
        .out_valid(out_valid), .out_ready(out_ready), .out_hit(out_hit),
        .out_neg(out_neg), .flag_z(flag_z), .flag_n(flag_n), .flag_clr(flag_clr)
    );

    // Parameter-sweep instances
    logic        a_valid, a_mode, a_ready, a_ovalid, a_hit, a_neg, a_z, a_n;
    logic [31:0] a_data;
    logic        b_valid, b_mode, b_ready, b_ovalid, b_hit, b_neg, b_z, b_n;
    logic [15:0] b_data;

    zero_detect_pipe #(.WIDTH(32), .GROUP(8)) u_w32 (
        .clk(clk), .reset_n(reset_n), .in_valid(a_valid), .in_ready(a_ready),
        .in_data(a_data), .in_mode(a_mode), .in_setflags(1'b0),
        .out_valid(a_ovalid), .out_ready(1'b1), .out_hit(a_hit),
        .out_neg(a_neg), .flag_z(a_z), .flag_n(a_n), .flag_clr(1'b0)
    );

    zero_detect_pipe #(.WIDTH(16), .GROUP(16)) u_w16 (
        .clk(clk), .reset_n(reset_n), .in_valid(b_valid), .in_ready(b_ready),
        .in_data(b_data), .in_mode(b_mode), .in_setflags(1'b0),
        .out_valid(b_ovalid), .out_ready(1'b1), .out_hit(b_hit),
        .out_neg(b_neg), .flag_z(b_z), .flag_n(b_n), .flag_clr(1'b0)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: results queued in arrival order; the head sits in the output
    // stage once it has had a cycle to move there.
    typedef struct {
        logic hit;
        logic neg;
        logic setflags;
    } item_t;

    item_t mq[$];
    bit    head_out;
    logic  mz, mn;
    bit    model_live = 1'b0;
    bit    m_pop, m_mid_busy, m_mid_moves, m_take;
    item_t m_item;

    function automatic logic ref_hit(input logic [W-1:0] d, input logic m);
        return m ? (d == {W{1'b1}}) : (d == {W{1'b0}});
    endfunction

    always @(posedge clk) begin
        model_live = 1'b1;
        if (!reset_n) begin
            mq.delete();
            head_out = 1'b0;
            mz = 1'b0;
            mn = 1'b0;
        end else begin
            m_pop       = head_out && out_ready;
            m_mid_busy  = mq.size() > (head_out ? 1 : 0);
            m_mid_moves = m_mid_busy && (!head_out || out_ready);
            m_take      = in_valid && (!m_mid_busy || m_mid_moves);
            if (flag_clr) begin
                mz = 1'b0;
                mn = 1'b0;
            end else if (m_pop && mq[0].setflags) begin
                mz = mq[0].hit;
                mn = mq[0].neg;
            end
            if (m_pop) begin
                void'(mq.pop_front());
                head_out = 1'b0;
            end
            if (m_mid_moves) head_out = 1'b1;
            if (m_take) begin
                m_item.hit      = ref_hit(in_data, in_mode);
                m_item.neg      = in_data[W-1];
                m_item.setflags = in_setflags;
                mq.push_back(m_item);
            end
        end
    end

    bit c_ev, c_mid_busy, c_er;

    always @(negedge clk) begin
        if (model_live) begin
            c_ev       = head_out && (mq.size() > 0);
            c_mid_busy = mq.size() > (head_out ? 1 : 0);
            c_er       = !c_mid_busy || !head_out || out_ready;
            check("model_out_valid", out_valid, c_ev);
            check("model_in_ready", in_ready, c_er);
            if (c_ev) begin
                check("model_out_hit", out_hit, mq[0].hit);
                check("model_out_neg", out_neg, mq[0].neg);
            end
            check("model_flag_z", flag_z, mz);
            check("model_flag_n", flag_n, mn);
        end
    end

    int dut_delivered = 0;
    int dut_hits      = 0;

    always @(posedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            dut_delivered++;
            if (out_hit) dut_hits++;
        end
    end

    // One isolated operand with out_ready high; clr is raised on its handshake cycle.
    task automatic run_one(input string name, input logic [63:0] d, input logic m,
                           input logic sf, input logic clr, input logic eh, input logic en);
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = d; in_mode = m; in_setflags = sf;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        flag_clr = clr;
        check({name, "_valid"}, out_valid, 1'b1);
        check({name, "_hit"}, out_hit, eh);
        check({name, "_neg"}, out_neg, en);
        @(posedge clk); #1;
        flag_clr = 1'b0;
    endtask

    task automatic sweep32(input logic [31:0] d, input logic m, input logic eh);
        @(posedge clk); #1;
        a_valid = 1'b1; a_data = d; a_mode = m;
        @(posedge clk); #1;
        a_valid = 1'b0;
        @(posedge clk); #1;
        check("w32_valid", a_ovalid, 1'b1);
        check("w32_hit", a_hit, eh);
        check("w32_neg", a_neg, d[31]);
    endtask

    task automatic sweep16(input logic [15:0] d, input logic m, input logic eh);
        @(posedge clk); #1;
        b_valid = 1'b1; b_data = d; b_mode = m;
        @(posedge clk); #1;
        b_valid = 1'b0;
        @(posedge clk); #1;
        check("w16_valid", b_ovalid, 1'b1);
        check("w16_hit", b_hit, eh);
        check("w16_neg", b_neg, d[15]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] one64;
        logic [31:0] one32;
        logic [15:0] one16;
        int d0, h0, i, c;
        bit acc;

        one64 = 64'd1; one32 = 32'd1; one16 = 16'd1;
        reset_n = 1'b0; in_valid = 1'b1; in_data = '1; in_mode = 1'b0;
        in_setflags = 1'b1; out_ready = 1'b1; flag_clr = 1'b0;
        a_valid = 1'b0; a_data = '0; a_mode = 1'b0;
        b_valid = 1'b0; b_data = '0; b_mode = 1'b0;

        // Reset with a valid operand pending
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_hit", out_hit, 1'b0);
        check("rst_flag_z", flag_z, 1'b0);
        check("rst_flag_n", flag_n, 1'b0);
        reset_n = 1'b1; in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            check("post_rst_quiet", out_valid, 1'b0);
        end

        // Back-to-back zero detect
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = 64'h0; in_mode = 1'b0; in_setflags = 1'b1;
        @(posedge clk); #1;
        in_data = 64'h1; in_setflags = 1'b0;
        @(posedge clk); #1;
        in_data = 64'h8000_0000_0000_0000; in_setflags = 1'b1;
        check("zd0_valid", out_valid, 1'b1);
        check("zd0_hit", out_hit, 1'b1);
        check("zd0_neg", out_neg, 1'b0);
        check("zd0_flag_z", flag_z, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("zd1_hit", out_hit, 1'b0);
        check("zd1_neg", out_neg, 1'b0);
        check("zd1_flag_z", flag_z, 1'b1);
        check("zd1_flag_n", flag_n, 1'b0);
        @(posedge clk); #1;
        check("zd2_hit", out_hit, 1'b0);
        check("zd2_neg", out_neg, 1'b1);
        check("zd2_flag_z", flag_z, 1'b1);
        @(posedge clk); #1;
        check("zd_drained", out_valid, 1'b0);
        check("zd3_flag_z", flag_z, 1'b0);
        check("zd3_flag_n", flag_n, 1'b1);

        // Ones detect
        run_one("ones_all", 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        run_one("ones_fe", 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        run_one("ones_zero", 64'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Flag priority and setflags=0
        run_one("fp_set", 64'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        check("fp_set_z", flag_z, 1'b1);
        run_one("fp_clr", 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        check("fp_clr_z", flag_z, 1'b0);
        check("fp_clr_n", flag_n, 1'b0);
        run_one("fp_set2", 64'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        run_one("fp_nosf", 64'h8000_0000_0000_0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("fp_nosf_z", flag_z, 1'b1);
        check("fp_nosf_n", flag_n, 1'b0);

        // Backpressure: two operands stall, then a stream with out_ready 1,0,0,...
        d0 = dut_delivered; h0 = dut_hits;
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b1; in_data = 64'd0; in_mode = 1'b0; in_setflags = 1'b0;
        @(posedge clk); #1;
        in_data = 64'd1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_in_ready_low", in_ready, 1'b0);
        check("bp_out_valid", out_valid, 1'b1);
        check("bp_head_hit", out_hit, 1'b1);
        i = 2; c = 0;
        while ((i < 10 || (dut_delivered - d0) < 10) && c < 200) begin
            out_ready = (c % 3 == 0);
            in_valid = (i < 10); in_data = 64'(i);
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) i++;
            c++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check("bp_no_timeout", 64'(c < 200), 64'd1);
        check("bp_delivered", 64'(dut_delivered - d0), 64'd10);
        check("bp_hits", 64'(dut_hits - h0), 64'd1);

        // Randomized traffic against the model, with one mid-run reset
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk); #1;
            reset_n     = (n != 1500);
            in_valid    = ($urandom_range(0, 3) != 0);
            in_mode     = $urandom_range(0, 1);
            in_setflags = $urandom_range(0, 1);
            out_ready   = ($urandom_range(0, 2) != 0);
            flag_clr    = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 5))
                0: in_data = '0;
                1: in_data = '1;
                2: in_data = one64 << $urandom_range(0, 63);
                3: in_data = ~(one64 << $urandom_range(0, 63));
                4: in_data = {$urandom, $urandom};
                default: in_data = 64'h8000_0000_0000_0000;
            endcase
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1; flag_clr = 1'b0; reset_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("rand_drained", out_valid, 1'b0);

        // Parameter sweep
        for (int k = 0; k < 32; k++) sweep32(one32 << k, 1'b0, 1'b0);
        sweep32(32'h0, 1'b0, 1'b1);
        sweep32(32'hFFFF_FFFF, 1'b1, 1'b1);
        sweep32(32'hFFFF_FF7F, 1'b1, 1'b0);
        for (int k = 0; k < 16; k++) sweep16(one16 << k, 1'b0, 1'b0);
        sweep16(16'h0, 1'b0, 1'b1);
        sweep16(16'hFFFF, 1'b1, 1'b1);
        sweep16(16'hFEFF, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
